// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the shared tagged 64-bit memory bus.
// The arbiter connects through the slave modport; requesters and memory use master.
interface mem_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  logic [2*NREQ-1:0]  req_op;
  logic [20*NREQ-1:0] req_addr;
  logic [64*NREQ-1:0] req_wdata;
  logic [8*NREQ-1:0]  req_wtag;
  logic [NREQ-1:0]    req_wvalid;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rd_ack;
  logic [NREQ-1:0]    ack;
  logic [63:0]        rdata;
  logic [7:0]         rtag;
  logic [63:0]        m_ad;
  logic [7:0]         m_tag;
  logic               m_astb;
  logic               m_atomic;
  logic               m_rd;
  logic               m_wr;
  logic [63:0]        m_data;
  logic [7:0]         m_itag;

  modport slave (
    input  req_op, req_addr, req_wdata, req_wtag, req_wvalid, m_data, m_itag,
    output gnt, rd_ack, ack, rdata, rtag, m_ad, m_tag, m_astb, m_atomic, m_rd, m_wr
  );

  modport master (
    output req_op, req_addr, req_wdata, req_wtag, req_wvalid, m_data, m_itag,
    input  gnt, rd_ack, ack, rdata, rtag, m_ad, m_tag, m_astb, m_atomic, m_rd, m_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one tagged memory bus between NREQ requesters;
// sequences read, write and locked read-modify-write transactions onto the strobes.
module mem_arbiter #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned RD_LAT = 1
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned IWP = IW + 1;
  localparam int unsigned CW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned AW  = 20;
  localparam int unsigned DW  = 64;
  localparam int unsigned TW  = 8;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_AT   = 2'b11;

  typedef enum logic [2:0] {IDLE, ADDR, RD, RWAIT, WHOLD, WR, DONE} state_e;

  state_e          state_q;
  logic [IW-1:0]   owner_q, last_q;
  logic [1:0]      op_q;
  logic [DW-1:0]   wdata_q;
  logic [TW-1:0]   wtag_q;
  logic [CW-1:0]   cnt_q;
  logic            whold_first_q;
  logic [NREQ-1:0] gnt_q, rd_ack_q, ack_q;
  logic [DW-1:0]   rdata_q, m_ad_q;
  logic [TW-1:0]   rtag_q, m_tag_q;
  logic            m_astb_q, m_atomic_q, m_rd_q, m_wr_q;

  logic [1:0]    op_a    [NREQ];
  logic [AW-1:0] addr_a  [NREQ];
  logic [DW-1:0] wdata_a [NREQ];
  logic [TW-1:0] wtag_a  [NREQ];
  logic          wvld_a  [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_a[g]    = bus.req_op[2*g +: 2];
    assign addr_a[g]  = bus.req_addr[AW*g +: AW];
    assign wdata_a[g] = bus.req_wdata[DW*g +: DW];
    assign wtag_a[g]  = bus.req_wtag[TW*g +: TW];
    assign wvld_a[g]  = bus.req_wvalid[g];
  end

  // Round-robin scan starting just past the last owner.
  logic [IW-1:0] pick_d;
  logic          pick_vld_d;
  logic [IW:0]   scan_idx;

  always_comb begin
    pick_d     = last_q;
    pick_vld_d = 1'b0;
    scan_idx   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      scan_idx = IWP'(last_q) + IWP'(i);
      if (scan_idx >= IWP'(NREQ)) scan_idx = scan_idx - IWP'(NREQ);
      if (!pick_vld_d && op_a[scan_idx[IW-1:0]] != OP_NONE) begin
        pick_vld_d = 1'b1;
        pick_d     = scan_idx[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      last_q        <= IW'(NREQ - 1);
      op_q          <= OP_NONE;
      wdata_q       <= '0;
      wtag_q        <= '0;
      cnt_q         <= '0;
      whold_first_q <= 1'b0;
      gnt_q         <= '0;
      rd_ack_q      <= '0;
      ack_q         <= '0;
      rdata_q       <= '0;
      rtag_q        <= '0;
      m_ad_q        <= '0;
      m_tag_q       <= '0;
      m_astb_q      <= 1'b0;
      m_atomic_q    <= 1'b0;
      m_rd_q        <= 1'b0;
      m_wr_q        <= 1'b0;
    end else begin
      rd_ack_q <= '0;
      ack_q    <= '0;
      case (state_q)
        IDLE: begin
          if (pick_vld_d) begin
            owner_q    <= pick_d;
            last_q     <= pick_d;
            op_q       <= op_a[pick_d];
            wdata_q    <= wdata_a[pick_d];
            wtag_q     <= wtag_a[pick_d];
            gnt_q      <= NREQ'(1) << pick_d;
            m_astb_q   <= 1'b1;
            m_ad_q     <= DW'(addr_a[pick_d]);
            m_atomic_q <= (op_a[pick_d] == OP_AT);
            state_q    <= ADDR;
          end
        end
        ADDR: begin
          m_astb_q <= 1'b0;
          if (op_q == OP_WR) begin
            m_wr_q  <= 1'b1;
            m_ad_q  <= wdata_q;
            m_tag_q <= wtag_q;
            state_q <= WR;
          end else begin
            m_ad_q  <= '0;
            m_rd_q  <= 1'b1;
            state_q <= RD;
          end
        end
        RD: begin
          m_rd_q  <= 1'b0;
          cnt_q   <= CW'(RD_LAT - 1);
          state_q <= RWAIT;
        end
        RWAIT: begin
          if (cnt_q == '0) begin
            rdata_q  <= bus.m_data;
            rtag_q   <= bus.m_itag;
            rd_ack_q <= gnt_q;
            if (op_q == OP_AT) begin
              whold_first_q <= 1'b1;
              state_q       <= WHOLD;
            end else begin
              ack_q   <= gnt_q;
              state_q <= DONE;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        // Bus stays locked; the owner supplies new data or withdraws.
        WHOLD: begin
          whold_first_q <= 1'b0;
          if (!whold_first_q) begin
            if (wvld_a[owner_q]) begin
              m_wr_q  <= 1'b1;
              m_ad_q  <= wdata_a[owner_q];
              m_tag_q <= wtag_a[owner_q];
              state_q <= WR;
            end else if (op_a[owner_q] == OP_NONE) begin
              gnt_q      <= '0;
              m_atomic_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
        end
        WR: begin
          m_wr_q     <= 1'b0;
          m_ad_q     <= '0;
          m_tag_q    <= '0;
          m_atomic_q <= 1'b0;
          ack_q      <= gnt_q;
          state_q    <= DONE;
        end
        DONE: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.rd_ack   = rd_ack_q;
  assign bus.ack      = ack_q;
  assign bus.rdata    = rdata_q;
  assign bus.rtag     = rtag_q;
  assign bus.m_ad     = m_ad_q;
  assign bus.m_tag    = m_tag_q;
  assign bus.m_astb   = m_astb_q;
  assign bus.m_atomic = m_atomic_q;
  assign bus.m_rd     = m_rd_q;
  assign bus.m_wr     = m_wr_q;
endmodule
